ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter; the send direction of the keyboard link whose receive side feeds the 2048 game's direction/reset keys. It accepts one command byte per valid/ready handshake, runs the PS/2 request-to-send sequence on the shared open-drain `ps2_clk`/`ps2_data` lines, and reports device acknowledge or timeout. Typical users: keyboard reset (0xFF) at power-up and LED updates (0xED plus argument) from game state.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 141 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command/response codes for the host transmit and receive paths.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INHIBIT = 3'd1,
      ST_REQ     = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_ACK     = 3'd4,
      ST_RELEASE = 3'd5
   } ps2_state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] RESP_ACK     = 8'hFA;
   localparam logic [7:0] RESP_RESEND  = 8'hFE;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads with a falling-edge strobe on clock.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   input  logic data_in,
   output logic clk_sync,
   output logic data_sync,
   output logic fall
);

   logic clk_meta;
   logic data_meta;
   logic clk_prev;

   // Lines idle high, so reset the chain to 1 to avoid a false edge after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= data_in;
         data_sync <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shift, ACK sample, timeout abort.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 12000,
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_inhibit,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout
);

   localparam int unsigned IW = $clog2(INHIBIT_CYC);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   ps2_state_t    state;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic [9:0]    frame;
   logic [3:0]    bit_cnt;
   logic          ack_bit;
   logic          clk_s;
   logic          data_s;
   logic          fall;
   logic          accept;
   logic          timed;
   logic          expired;

   ps2_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .clk_in    (ps2_clk_in),
      .data_in   (ps2_data_in),
      .clk_sync  (clk_s),
      .data_sync (data_s),
      .fall      (fall)
   );

   // Ready is held off during the done/timeout pulse so it returns the cycle after.
   assign tx_ready   = (state == ST_IDLE) & ~done & ~timeout;
   assign rx_inhibit = (state != ST_IDLE);
   assign accept     = tx_valid & tx_ready;
   assign timed      = (state == ST_REQ) || (state == ST_SHIFT) ||
                       (state == ST_ACK) || (state == ST_RELEASE);
   assign expired    = (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         frame       <= '0;
         bit_cnt     <= '0;
         ack_bit     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         done    <= 1'b0;
         ack_ok  <= 1'b0;
         timeout <= 1'b0;
         if (timed && expired) begin
            state       <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout     <= 1'b1;
         end else begin
            if (timed && (to_cnt < TW'(TIMEOUT_CYC)))
               to_cnt <= to_cnt + TW'(1);
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     frame      <= {1'b1, odd_parity(tx_data), tx_data};
                     inh_cnt    <= '0;
                     ps2_clk_oe <= 1'b1;
                     state      <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  // Data is pulled low one cycle before the clock is released.
                  if (inh_cnt == IW'(INHIBIT_CYC - 2))
                     ps2_data_oe <= 1'b1;
                  if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                     ps2_clk_oe <= 1'b0;
                     to_cnt     <= '0;
                     state      <= ST_REQ;
                  end else begin
                     inh_cnt <= inh_cnt + IW'(1);
                  end
               end
               ST_REQ: begin
                  if (fall) begin
                     ps2_data_oe <= ~frame[0];
                     frame       <= {1'b0, frame[9:1]};
                     bit_cnt     <= 4'd1;
                     state       <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (fall) begin
                     ps2_data_oe <= ~frame[0];
                     frame       <= {1'b0, frame[9:1]};
                     bit_cnt     <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd9)
                        state <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  if (fall) begin
                     ack_bit <= ~data_s;
                     state   <= ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (clk_s && data_s) begin
                     done   <= 1'b1;
                     ack_ok <= ack_bit;
                     state  <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple clocking PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned INH = 10000;
   localparam int unsigned TO  = 4000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       rx_inhibit;
   logic       done;
   logic       ack_ok;
   logic       timeout;
   logic       dev_clk_low;
   logic       dev_data_low;
   logic       glitch;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .rx_inhibit  (rx_inhibit),
      .done        (done),
      .ack_ok      (ack_ok),
      .timeout     (timeout)
   );

   // Open-drain pads with pull-ups; glitch inverts the clock pad level briefly.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low) ^ glitch;
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_tx(input string tag, input logic [7:0] b);
      for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
      check_vec({tag, "_ready"}, tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_vec({tag, "_clk_oe_1cyc"}, ps2_clk_oe, 1);
      check_vec({tag, "_busy"}, tx_ready, 0);
   endtask

   // Entered on the first sample with clk_oe high; stop_after>0 abandons the frame with clock low.
   task automatic dev_frame(input string tag, input bit do_ack, input bit glitch_en,
                            input int unsigned stop_after, output logic [9:0] bits);
      int unsigned n;
      logic        prev_doe;
      bit          seen;
      bits     = '0;
      n        = 1;
      prev_doe = ps2_data_oe;
      while (ps2_clk_oe && n < INH + 100) begin
         @(negedge clk);
         glitch = glitch_en && (n >= 200) && (n < 204);
         if (ps2_clk_oe) begin
            n++;
            prev_doe = ps2_data_oe;
         end
      end
      glitch = 1'b0;
      check_vec({tag, "_inhibit_len"}, n, INH);
      check_vec({tag, "_data_before_rel"}, prev_doe, 1);
      check_vec({tag, "_req_clk_oe"}, ps2_clk_oe, 0);
      repeat (10) @(negedge clk);
      check_vec({tag, "_start_bit"}, ps2_data_in, 0);
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) begin
            dev_data_low = do_ack;
            repeat (4) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (8) @(negedge clk);
         if (stop_after != 0 && k == int'(stop_after)) return;
         if (k <= 10) bits[k-1] = ps2_data_in;
         dev_clk_low = 1'b0;
         if (k < 11) repeat (8) @(negedge clk);
      end
      dev_data_low = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (timeout) check_vec({tag, "_no_timeout"}, timeout, 0);
         if (done) begin
            seen = 1'b1;
            check_vec({tag, "_ack_ok"}, ack_ok, do_ack);
            check_vec({tag, "_ready_low_on_done"}, tx_ready, 0);
         end
      end
      check_vec({tag, "_done_seen"}, seen, 1);
      @(negedge clk);
      check_vec({tag, "_ready_after"}, tx_ready, 1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  bits;
      int unsigned cnt;
      rst          = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      glitch       = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("rst_outputs", {tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, timeout},
                7'b1000000);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 0xED with ACK: LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1
      start_tx("ed", 8'hED);
      dev_frame("ed", 1'b1, 1'b0, 0, bits);
      check_vec("ed_bits", bits, 10'h3ED);

      // 0x01 without ACK: parity 0
      start_tx("01", 8'h01);
      dev_frame("01", 1'b0, 1'b0, 0, bits);
      check_vec("01_bits", bits, 10'h201);

      // 0xFF, device never clocks
      start_tx("ff", 8'hFF);
      for (int i = 0; i < INH + 100 && ps2_clk_oe; i++) @(negedge clk);
      check_vec("ff_req", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      cnt = 0;
      while (!timeout && cnt < TO + 100) begin
         @(negedge clk);
         cnt++;
         if (done) check_vec("ff_no_done", done, 0);
      end
      check_vec("ff_timeout_cycles", cnt, TO);
      check_vec("ff_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      @(negedge clk);
      check_vec("ff_after", {tx_ready, timeout, rx_inhibit}, 3'b100);

      // 0x00 aborted by reset after 5th fall, then resent
      start_tx("rst0", 8'h00);
      dev_frame("rst0", 1'b1, 1'b0, 5, bits);
      check_vec("rst0_mid_data_oe", ps2_data_oe, 1);
      rst = 1'b1;
      @(negedge clk);
      check_vec("rst0_released", {ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_ready}, 4'b0001);
      rst         = 1'b0;
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      start_tx("00", 8'h00);
      dev_frame("00", 1'b1, 1'b0, 0, bits);
      check_vec("00_bits", bits, 10'h300);

      // tx_valid held: 0xAA then 0x55 while busy; 0x55 taken when ready returns
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h55;
      check_vec("aa_clk_oe_1cyc", ps2_clk_oe, 1);
      dev_frame("aa", 1'b1, 1'b0, 0, bits);
      check_vec("aa_bits", bits, 10'h3AA);
      @(negedge clk);
      tx_valid = 1'b0;
      check_vec("55_accept", {ps2_clk_oe, tx_ready}, 2'b10);
      // Glitch on the clock pad during inhibit must not disturb the frame
      dev_frame("55", 1'b1, 1'b1, 0, bits);
      check_vec("55_bits", bits, 10'h355);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
